// File: rtl/crc_frame_pkg.sv
// Shared types and default K-code constants for the CRC frame encoder.
package crc_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC,
        ST_EOF
    } state_e;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

endpackage

// File: rtl/crc_byte_step.sv
// Combinational next-CRC for one byte: MSB-first, non-reflected, unrolled over 8 bits.
module crc_byte_step #(
    parameter int unsigned              CRC_WIDTH  = 8,
    parameter logic [CRC_WIDTH-1:0]     POLYNOMIAL = 'h07
) (
    input  logic [CRC_WIDTH-1:0] crc_i,
    input  logic [7:0]           data_i,
    output logic [CRC_WIDTH-1:0] crc_o
);

    function automatic logic [CRC_WIDTH-1:0] step_byte(input logic [CRC_WIDTH-1:0] c_in,
                                                       input logic [7:0]           d);
        logic [CRC_WIDTH-1:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[CRC_WIDTH-1] ^ d[i]) begin
                c = {c[CRC_WIDTH-2:0], 1'b0} ^ POLYNOMIAL;
            end else begin
                c = {c[CRC_WIDTH-2:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign crc_o = step_byte(crc_i, data_i);

endmodule

// File: rtl/crc_frame_encoder.sv
// Framing encoder: SOF, payload, CRC (MSB first), EOF, with idle/filler K-codes.
// Optional CRC error injection is enabled by defining CRC_FRAME_ERR_INJECT_EN.
module crc_frame_encoder
    import crc_frame_pkg::*;
#(
    parameter int unsigned          CRC_WIDTH   = 8,
    parameter logic [CRC_WIDTH-1:0] POLYNOMIAL  = 'h07,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT    = '0,
    parameter int unsigned          PAYLOAD_LEN = 8,
    parameter logic [7:0]           IDLE_K      = K28_5,
    parameter logic [7:0]           SOF_K       = K27_7,
    parameter logic [7:0]           EOF_K       = K29_7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  sym_o,
    output logic        sym_k_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic [15:0] frame_cnt_o
`ifdef CRC_FRAME_ERR_INJECT_EN
    ,
    input  logic        inject_err_i
`endif
);

    localparam int unsigned CRC_BYTES = CRC_WIDTH / 8;
    localparam logic [7:0]  LAST_IDX  = 8'(PAYLOAD_LEN - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d, crc_next;
    logic [1:0]           idx_q, idx_d;
    logic [7:0]           sym_q, sym_d;
    logic                 symk_q, symk_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 inj_q, inj_d;
    logic                 inject_req;
    logic [7:0]           crc_byte;

`ifdef CRC_FRAME_ERR_INJECT_EN
    assign inject_req = inject_err_i;
`else
    assign inject_req = 1'b0;
`endif

    crc_byte_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLYNOMIAL(POLYNOMIAL)
    ) u_step (
        .crc_i (crc_q),
        .data_i(in_data),
        .crc_o (crc_next)
    );

    // Upper byte first; the last byte out (index 0) carries the optional injected error.
    always_comb begin
        crc_byte = (idx_q != 2'd0) ? crc_q[CRC_WIDTH-1 -: 8] : crc_q[7:0];
        if (idx_q == 2'd0 && inj_q) begin
            crc_byte[0] = ~crc_byte[0];
        end
    end

    assign in_ready = (state_q == ST_PAYLOAD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        idx_d       = idx_q;
        sym_d       = IDLE_K;
        symk_d      = 1'b1;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        inj_d       = inj_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sym_d   = SOF_K;
                    sof_d   = 1'b1;
                    crc_d   = CRC_INIT;
                    cnt_d   = 8'd0;
                    inj_d   = inject_req;
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (in_valid) begin
                    sym_d  = in_data;
                    symk_d = 1'b0;
                    crc_d  = crc_next;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        idx_d   = 2'(CRC_BYTES - 1);
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                sym_d  = crc_byte;
                symk_d = 1'b0;
                if (idx_q == 2'd0) begin
                    state_d = ST_EOF;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            ST_EOF: begin
                sym_d       = EOF_K;
                eof_d       = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                inj_d       = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            crc_q       <= CRC_INIT;
            idx_q       <= 2'd0;
            sym_q       <= IDLE_K;
            symk_q      <= 1'b1;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            inj_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            idx_q       <= idx_d;
            sym_q       <= sym_d;
            symk_q      <= symk_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            frame_cnt_q <= frame_cnt_d;
            inj_q       <= inj_d;
        end
    end

    assign sym_o       = sym_q;
    assign sym_k_o     = symk_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
